// File: rtl/reg_transfer_pkg.sv
// Shared definitions for the register-transfer controller: op encodings, FSM states,
// the queued command record and the one-hot index decoder.
package reg_transfer_pkg;

    localparam int RT_DW = 16;

    typedef enum logic [1:0] {
        OP_MOVE = 2'b00,
        OP_IN   = 2'b01,
        OP_OUT  = 2'b10,
        OP_ILL  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        LATCH = 2'b10
    } state_e;

    typedef struct packed {
        op_e              op;
        logic [1:0]       src;
        logic [1:0]       dest;
        logic [RT_DW-1:0] data;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rt_cmd_fifo.sv
// Synchronous command FIFO with asynchronous active-high reset. Push is ignored when
// full and pop when empty; push and pop may coincide at any fill level.
module rt_cmd_fifo #(
    parameter int W     = 22,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Storage carries no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/reg_transfer_ctrl.sv
// Command-queued initiator for a 4 x DW shared-bus register file: sequences MOVE/IN/OUT
// strobes one command at a time. Build option RT_SKIP_SELF_EN retires self-MOVEs as no-ops.
module reg_transfer_ctrl
    import reg_transfer_pkg::*;
#(
    parameter int DW        = RT_DW,
    parameter int CMD_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    // cmd_valid/cmd_ready: a command transfers on any edge where both are high; the
    // fields must stay stable while cmd_valid is high and cmd_ready is low.
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [1:0]    cmd_src,
    input  logic [1:0]    cmd_dest,
    input  logic [DW-1:0] cmd_data,
    output logic [3:0]    enable,
    output logic [3:0]    load,
    output logic          bus_drv,
    output logic [DW-1:0] bus_out,
    input  logic [DW-1:0] bus_in,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          err
);
    cmd_t   in_cmd, head;
    logic   fifo_empty, fifo_full, pop;

    state_e        state_q;
    op_e           cur_op_q;
    logic [1:0]    cur_src_q, cur_dest_q;
    logic [3:0]    enable_q, load_q;
    logic          bus_drv_q, rd_valid_q, err_q;
    logic [DW-1:0] bus_out_q, rd_data_q;

    state_e        launch_state_d;
    logic [3:0]    launch_en_d, launch_ld_d;
    logic          launch_drv_d, launch_ill_d, self_skip;

    always_comb begin
        in_cmd      = '0;
        in_cmd.op   = op_e'(cmd_op);
        in_cmd.src  = cmd_src;
        in_cmd.dest = cmd_dest;
        in_cmd.data = cmd_data;
    end

    rt_cmd_fifo #(.W(CMD_W), .DEPTH(CMD_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (cmd_valid),
        .push_data_i (in_cmd),
        .pop_i       (pop),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    // The next command launches from IDLE or straight out of LATCH, so a busy queue
    // never sees a dead IDLE cycle between transfers.
    assign pop = !fifo_empty && (state_q == IDLE || state_q == LATCH);

`ifdef RT_SKIP_SELF_EN
    assign self_skip = (head.src == head.dest);
`else
    assign self_skip = 1'b0;
`endif

    always_comb begin
        launch_state_d = IDLE;
        launch_en_d    = 4'b0000;
        launch_ld_d    = 4'b0000;
        launch_drv_d   = 1'b0;
        launch_ill_d   = 1'b0;
        case (head.op)
            OP_MOVE: begin
                if (!self_skip) begin
                    launch_state_d = DRIVE;
                    launch_en_d    = onehot4(head.src);
                end
            end
            OP_OUT: begin
                launch_state_d = DRIVE;
                launch_en_d    = onehot4(head.src);
            end
            OP_IN: begin
                launch_state_d = LATCH;
                launch_ld_d    = onehot4(head.dest);
                launch_drv_d   = 1'b1;
            end
            default: launch_ill_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_op_q   <= OP_MOVE;
            cur_src_q  <= 2'b00;
            cur_dest_q <= 2'b00;
            enable_q   <= 4'b0000;
            load_q     <= 4'b0000;
            bus_drv_q  <= 1'b0;
            bus_out_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                DRIVE: begin
                    state_q  <= LATCH;
                    enable_q <= onehot4(cur_src_q);
                    load_q   <= (cur_op_q == OP_MOVE) ? onehot4(cur_dest_q) : 4'b0000;
                end
                LATCH: begin
                    if (cur_op_q == OP_OUT) begin
                        rd_data_q  <= bus_in;
                        rd_valid_q <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (pop) begin
                state_q    <= launch_state_d;
                cur_op_q   <= head.op;
                cur_src_q  <= head.src;
                cur_dest_q <= head.dest;
                enable_q   <= launch_en_d;
                load_q     <= launch_ld_d;
                bus_drv_q  <= launch_drv_d;
                bus_out_q  <= head.data;
                if (launch_ill_d) err_q <= 1'b1;
            end else if (state_q == LATCH) begin
                state_q   <= IDLE;
                enable_q  <= 4'b0000;
                load_q    <= 4'b0000;
                bus_drv_q <= 1'b0;
            end
        end
    end

    assign cmd_ready = !fifo_full;
    assign enable    = enable_q;
    assign load      = load_q;
    assign bus_drv   = bus_drv_q;
    assign bus_out   = bus_drv_q ? bus_out_q : {DW{1'bz}};
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;
    assign err       = err_q;

endmodule

// File: tb/tb_reg_transfer_ctrl.sv
// Bench for reg_transfer_ctrl: behavioural 4-register datapath on the shared bus,
// table-driven single-command traces, and hand sequences for queueing and reset.
module tb_reg_transfer_ctrl;
    import reg_transfer_pkg::*;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op, cmd_src, cmd_dest;
    logic [DW-1:0] cmd_data;
    logic [3:0]    enable, load;
    logic          bus_drv;
    wire  [DW-1:0] bus_out;
    logic [DW-1:0] bus_in;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          busy, err;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] ref_r [4];
    logic [DW-1:0] dp_r [4];
    logic [3:0]    dp_drv_q;

    always #5 clk = ~clk;

    reg_transfer_ctrl #(.DW(DW), .CMD_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_src   (cmd_src),
        .cmd_dest  (cmd_dest),
        .cmd_data  (cmd_data),
        .enable    (enable),
        .load      (load),
        .bus_drv   (bus_drv),
        .bus_out   (bus_out),
        .bus_in    (bus_in),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .busy      (busy),
        .err       (err)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        case (i)
            0:       return 16'h1111;
            1:       return 16'h2222;
            2:       return 16'h3333;
            default: return 16'h4444;
        endcase
    endfunction

    // Datapath model: a register drives the bus the cycle after its enable.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) dp_r[i] <= init_val(i);
            dp_drv_q <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) if (load[i]) dp_r[i] <= bus_in;
            dp_drv_q <= enable;
        end
    end

    always_comb begin
        bus_in = '0;
        if (bus_drv) begin
            bus_in = bus_out;
        end else begin
            for (int i = 0; i < 4; i++) bus_in = bus_in | (dp_drv_q[i] ? dp_r[i] : '0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dest,
                         input logic [DW-1:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = src;
        cmd_dest  = dest;
        cmd_data  = data;
    endtask

    task automatic model_accept(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dest,
                                input logic [DW-1:0] data);
        case (op)
            2'b00:   ref_r[dest] = ref_r[src];
            2'b01:   ref_r[dest] = data;
            2'b10:   exp_q.push_back(ref_r[src]);
            default: ;
        endcase
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) ref_r[i] = init_val(i);
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
        tick();
    endtask

    // Scoreboard: OUT results are popped when the controller reports them.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rd_unexpected", {31'd0, rd_valid}, 32'd0);
                end else begin
                    chk("rd_data", rd_data, exp_q.pop_front());
                end
            end
            if (|enable || |load || bus_drv) begin
                chk("strobe_excl", {29'd0, $onehot0(enable), $onehot0(load), !(bus_drv && |enable)},
                    32'd7);
            end
        end
    end

    typedef struct {
        logic [1:0]    op, src, dest;
        logic [DW-1:0] data;
        logic [15:0]   en_t, ld_t;
        logic [3:0]    drv_t, busy_t;
        logic          err_after;
    } vec_t;

    typedef struct {
        logic [1:0] op, src, dest;
    } fcmd_t;

    vec_t  tbl [9];
    fcmd_t fill [8];

    task automatic run_vec(input int k, input vec_t v);
        offer(v.op, v.src, v.dest, v.data);
        chk($sformatf("v%0d_ready", k), {31'd0, cmd_ready}, 32'd1);
        model_accept(v.op, v.src, v.dest, v.data);
        tick();
        cmd_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("v%0d_c%0d_enable", k, c + 1), {28'd0, enable}, {28'd0, v.en_t[15-4*c -: 4]});
            chk($sformatf("v%0d_c%0d_load", k, c + 1), {28'd0, load}, {28'd0, v.ld_t[15-4*c -: 4]});
            chk($sformatf("v%0d_c%0d_bus_drv", k, c + 1), {31'd0, bus_drv}, {31'd0, v.drv_t[3-c]});
            chk($sformatf("v%0d_c%0d_busy", k, c + 1), {31'd0, busy}, {31'd0, v.busy_t[3-c]});
            if (v.drv_t[3-c]) chk($sformatf("v%0d_bus_out", k), {16'd0, bus_out}, {16'd0, v.data});
            if (c < 3) tick();
        end
        chk($sformatf("v%0d_err", k), {31'd0, err}, {31'd0, v.err_after});
        wait_idle();
    endtask

    initial begin
        logic          rdy;
        int            idx, cyc;
        logic [8:0]    exp_rdy;

        tbl[0] = '{2'b01, 2'd0, 2'd2, 16'hA5A5, 16'h0000, 16'h0400, 4'b0100, 4'b1100, 1'b0};
        tbl[1] = '{2'b00, 2'd2, 2'd0, 16'h0000, 16'h0440, 16'h0010, 4'b0000, 4'b1110, 1'b0};
        tbl[2] = '{2'b10, 2'd0, 2'd0, 16'h0000, 16'h0110, 16'h0000, 4'b0000, 4'b1110, 1'b0};
        tbl[3] = '{2'b01, 2'd0, 2'd1, 16'h1234, 16'h0000, 16'h0200, 4'b0100, 4'b1100, 1'b0};
        tbl[4] = '{2'b00, 2'd1, 2'd3, 16'h0000, 16'h0220, 16'h0080, 4'b0000, 4'b1110, 1'b0};
        tbl[5] = '{2'b11, 2'd1, 2'd2, 16'hFFFF, 16'h0000, 16'h0000, 4'b0000, 4'b1000, 1'b1};
        tbl[6] = '{2'b10, 2'd3, 2'd0, 16'h0000, 16'h0880, 16'h0000, 4'b0000, 4'b1110, 1'b1};
`ifdef RT_SKIP_SELF_EN
        tbl[7] = '{2'b00, 2'd3, 2'd3, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 4'b1000, 1'b1};
`else
        tbl[7] = '{2'b00, 2'd3, 2'd3, 16'h0000, 16'h0880, 16'h0080, 4'b0000, 4'b1110, 1'b1};
`endif
        tbl[8] = '{2'b10, 2'd2, 2'd0, 16'h0000, 16'h0440, 16'h0000, 4'b0000, 4'b1110, 1'b1};

        fill[0] = '{2'b00, 2'd0, 2'd1};
        fill[1] = '{2'b10, 2'd1, 2'd0};
        fill[2] = '{2'b00, 2'd2, 2'd3};
        fill[3] = '{2'b10, 2'd3, 2'd0};
        fill[4] = '{2'b00, 2'd1, 2'd2};
        fill[5] = '{2'b10, 2'd2, 2'd0};
        fill[6] = '{2'b10, 2'd0, 2'd0};
        fill[7] = '{2'b00, 2'd3, 2'd0};

        cmd_valid = 1'b0;
        cmd_op = 2'b00; cmd_src = 2'b00; cmd_dest = 2'b00; cmd_data = '0;
        rst = 1'b1;
        do_reset();

        // Reset state
        chk("rst_enable", {28'd0, enable}, 32'd0);
        chk("rst_load", {28'd0, load}, 32'd0);
        chk("rst_bus_drv", {31'd0, bus_drv}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Single commands into an idle controller
        for (int k = 0; k < 9; k++) run_vec(k, tbl[k]);
        for (int i = 0; i < 4; i++) chk($sformatf("tbl_reg%0d", i), {16'd0, dp_r[i]}, {16'd0, ref_r[i]});

        // Illegal op followed immediately by OUT
        do_reset();
        offer(2'b11, 2'd1, 2'd2, 16'hDEAD);
        tick();
        offer(2'b10, 2'd1, 2'd0, 16'h0000);
        model_accept(2'b10, 2'd1, 2'd0, 16'h0000);
        chk("ill_c1_strobes", {23'd0, enable, load, bus_drv}, 32'd0);
        chk("ill_c1_err", {31'd0, err}, 32'd0);
        tick();
        cmd_valid = 1'b0;
        chk("ill_c2_strobes", {23'd0, enable, load, bus_drv}, 32'd0);
        chk("ill_c2_err", {31'd0, err}, 32'd1);
        tick();
        chk("ill_out_drive", {28'd0, enable}, 32'h2);
        wait_idle();
        chk("ill_err_sticky", {31'd0, err}, 32'd1);

        // Back-to-back stream: queue fills while the controller works
        exp_rdy = 9'b111111010;
        idx = 0;
        cyc = 0;
        offer(fill[0].op, fill[0].src, fill[0].dest, 16'h0000);
        while (idx < 8 && cyc < 40) begin
            rdy = cmd_ready;
            tick();
            cyc++;
            if (rdy) begin
                model_accept(fill[idx].op, fill[idx].src, fill[idx].dest, 16'h0000);
                idx++;
                if (idx < 8) offer(fill[idx].op, fill[idx].src, fill[idx].dest, 16'h0000);
                else cmd_valid = 1'b0;
            end
            if (cyc <= 9) chk($sformatf("fill_ready_c%0d", cyc), {31'd0, cmd_ready}, {31'd0, exp_rdy[9-cyc]});
        end
        cmd_valid = 1'b0;
        chk("fill_accepted", idx, 32'd8);
        wait_idle();
        for (int i = 0; i < 4; i++) chk($sformatf("fill_reg%0d", i), {16'd0, dp_r[i]}, {16'd0, ref_r[i]});

        // Reset in the LATCH cycle of a MOVE with more commands queued
        offer(2'b00, 2'd0, 2'd1, 16'h0000);
        tick();
        offer(2'b00, 2'd2, 2'd3, 16'h0000);
        tick();
        offer(2'b10, 2'd0, 2'd0, 16'h0000);
        tick();
        cmd_valid = 1'b0;
        chk("mid_latch_load", {28'd0, load}, 32'h2);
        chk("mid_latch_enable", {28'd0, enable}, 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_strobes", {23'd0, enable, load, bus_drv}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        for (int i = 0; i < 4; i++) ref_r[i] = init_val(i);
        exp_q.delete();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("post_rst_c%0d", c), {22'd0, enable, load, bus_drv, busy}, 32'd0);
        end

        chk("exp_q_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
